// File: rtl/ifm_mem_sequencer.sv
// -----------------------------------------------------------------------------
// ifm_mem_sequencer
//
// Purpose
//   Sequences one input feature map (IFM) through a true-dual-port buffer of
//   N = IFM_SIZE*IFM_SIZE words. Each start handles one map:
//     * Port A is write-only. It captures a raster input stream into
//       addresses 0..N-1.
//     * Port B is read-only. It drains the map in raster order through a
//       2-entry skid FIFO to the next stage, with valid/ready backpressure.
//
// Optional feature (compile-time macro)
//   IFM_SEQ_OVERLAP_EN : when defined, reads may start during LOAD for any
//                        address already written (rc < wc), so the drain
//                        overlaps the load. When undefined, reads happen
//                        only in DRAIN.
//
// Handshake semantics (both streams)
//   A word moves on a rising clock edge exactly when valid and ready are
//   both high in the preceding cycle. A producer that raises valid holds it
//   and its data stable until the transfer. Ready may change freely.
//
// Ports
//   clk, reset           clock (rising edge), synchronous active-high reset
//   start                begins one map; sampled only in IDLE
//   busy                 high while in LOAD or DRAIN
//   done                 1-cycle pulse after the last word is accepted
//   in_valid/in_ready    input stream handshake, in_data is the word
//   out_valid/out_ready  output stream handshake, out_data is the FIFO head
//   Address_A, Enable_Write_A_Mem, Enable_Read_A_Mem, Data_Input_A_Mem1
//                        memory port A (write only)
//   Address_B, Enable_Read_B_Mem, Enable_Write_B_Mem, Data_Output_B_Mem1
//                        memory port B (read only, 1-cycle read latency)
//   dbg_state            current FSM state (0 IDLE, 1 LOAD, 2 DRAIN)
// -----------------------------------------------------------------------------
module ifm_mem_sequencer #(
  parameter int DATA_WIDTH       = 32,
  parameter int IFM_SIZE         = 16,
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       out_data,
  input  logic                        out_ready,
  output logic [ADDRESS_SIZE_IFM-1:0] Address_A,
  output logic                        Enable_Write_A_Mem,
  output logic                        Enable_Read_A_Mem,
  output logic [DATA_WIDTH-1:0]       Data_Input_A_Mem1,
  output logic [ADDRESS_SIZE_IFM-1:0] Address_B,
  output logic                        Enable_Read_B_Mem,
  output logic                        Enable_Write_B_Mem,
  input  logic [DATA_WIDTH-1:0]       Data_Output_B_Mem1,
  output logic [1:0]                  dbg_state
);

  localparam int N  = IFM_SIZE * IFM_SIZE;
  // Counters run 0..N inclusive, so they need one bit beyond the address.
  localparam int CW = ADDRESS_SIZE_IFM + 1;

  localparam logic [CW-1:0] N_CNT    = CW'(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [CW-1:0]         wc;          // words written so far
  logic [CW-1:0]         rc;          // reads issued so far
  logic                  inflight;    // read issued last cycle, data on Data_Output_B_Mem1 now
  logic [1:0]            fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [DATA_WIDTH-1:0] fifo_tail;

  logic                  wr_fire;
  logic                  rd_allowed;
  logic                  rd_issue;
  logic                  push;
  logic                  pop;
  logic                  last_pop;
  logic                  map_start;
  logic                  load_done;
  logic [2:0]            occ;

  // ---------------------------------------------------------------------------
  // Handshake and read-issue logic
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    wr_fire   = 1'b0;
    map_start = 1'b0;
    load_done = 1'b0;
    out_valid = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    last_pop  = 1'b0;
    rd_allowed = 1'b0;
    occ       = 3'd0;
    rd_issue  = 1'b0;

    in_ready  = (state == S_LOAD) && (wc < N_CNT);
    wr_fire   = in_valid && in_ready;
    map_start = (state == S_IDLE) && start;
    load_done = wr_fire && (wc == LAST_CNT);

    out_valid = (fifo_count != 2'd0);
    push      = inflight;
    pop       = out_valid && out_ready;

    // The final word leaves when every read has been issued, nothing is in
    // flight and it is the only entry left in the FIFO.
    last_pop  = pop && (rc == N_CNT) && !inflight && (fifo_count == 2'd1);

`ifdef IFM_SEQ_OVERLAP_EN
    // rc < wc is strict, so the read address is always an already-written
    // word and never equals the address being written this cycle.
    rd_allowed = (state == S_DRAIN) || ((state == S_LOAD) && (rc < wc));
`else
    rd_allowed = (state == S_DRAIN);
`endif

    // Occupancy the FIFO will have once this cycle's pop and in-flight push
    // settle. A pop frees its slot in the same cycle, which is what lets the
    // drain sustain one word per cycle while still bounding FIFO entries plus
    // the in-flight word to two.
    occ      = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    rd_issue = rd_allowed && (rc < N_CNT) && (occ < 3'd2);
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
`ifdef IFM_SEQ_OVERLAP_EN
        if (last_pop) begin
          state_nxt = S_IDLE;
        end else if (load_done) begin
          state_nxt = S_DRAIN;
        end
`else
        if (load_done) begin
          state_nxt = S_DRAIN;
        end
`endif
      end
      S_DRAIN: begin
        if (last_pop) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters, in-flight flag, done pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wc       <= '0;
      rc       <= '0;
      inflight <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      // Read data returning after a reset is simply never captured.
      inflight <= rd_issue;
      done     <= last_pop;
      if (map_start) begin
        wc <= '0;
        rc <= '0;
      end else begin
        // Both guards already imply the counter is below N, so they saturate.
        if (wr_fire) begin
          wc <= wc + 1'b1;
        end
        if (rd_issue) begin
          rc <= rc + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry skid FIFO. fifo_head is the registered output word, fifo_tail
  // holds the second entry. The credit check above prevents a push into a
  // full FIFO.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_count <= 2'd0;
      fifo_head  <= '0;
      fifo_tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fifo_count == 2'd0) begin
            fifo_head <= Data_Output_B_Mem1;
          end else begin
            fifo_tail <= Data_Output_B_Mem1;
          end
          fifo_count <= fifo_count + 2'd1;
        end
        2'b01: begin
          if (fifo_count == 2'd2) begin
            fifo_head <= fifo_tail;
          end
          fifo_count <= fifo_count - 2'd1;
        end
        2'b11: begin
          if (fifo_count == 2'd1) begin
            fifo_head <= Data_Output_B_Mem1;
          end else begin
            fifo_head <= fifo_tail;
            fifo_tail <= Data_Output_B_Mem1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy               = (state == S_LOAD) || (state == S_DRAIN);
  assign out_data           = fifo_head;
  assign Address_A          = wc[ADDRESS_SIZE_IFM-1:0];
  assign Enable_Write_A_Mem = wr_fire;
  assign Enable_Read_A_Mem  = 1'b0;
  assign Data_Input_A_Mem1  = in_data;
  assign Address_B          = rc[ADDRESS_SIZE_IFM-1:0];
  assign Enable_Read_B_Mem  = rd_issue;
  assign Enable_Write_B_Mem = 1'b0;
  assign dbg_state          = state;

endmodule

// File: tb/tb_ifm_mem_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ifm_mem_sequencer
//
// Bench for ifm_mem_sequencer with IFM_SIZE=4 (N=16). A behavioural
// true-dual-port RAM sits on ports A/B. A negedge monitor checks every
// accepted output word against exp_q and tracks writes, reads, done pulses,
// outstanding reads and same-address read/write.
// -----------------------------------------------------------------------------
module tb_ifm_mem_sequencer;

  localparam int DW  = 32;
  localparam int IFM = 4;
  localparam int N   = IFM * IFM;
  localparam int AW  = 4;
  localparam int NV  = 38;

`ifdef IFM_SEQ_OVERLAP_EN
  localparam int FIRST_RE = 2;
  localparam int FIRST_OV = 4;
`else
  localparam int FIRST_RE = 17;
  localparam int FIRST_OV = 19;
`endif
  localparam int LAST = FIRST_OV + N - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [AW-1:0] Address_A;
  logic          Enable_Write_A_Mem;
  logic          Enable_Read_A_Mem;
  logic [DW-1:0] Data_Input_A_Mem1;
  logic [AW-1:0] Address_B;
  logic          Enable_Read_B_Mem;
  logic          Enable_Write_B_Mem;
  logic [DW-1:0] Data_Output_B_Mem1;
  logic [1:0]    dbg_state;

  ifm_mem_sequencer #(
    .DATA_WIDTH(DW),
    .IFM_SIZE(IFM),
    .ADDRESS_SIZE_IFM(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .busy(busy),
    .done(done),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .Address_A(Address_A),
    .Enable_Write_A_Mem(Enable_Write_A_Mem),
    .Enable_Read_A_Mem(Enable_Read_A_Mem),
    .Data_Input_A_Mem1(Data_Input_A_Mem1),
    .Address_B(Address_B),
    .Enable_Read_B_Mem(Enable_Read_B_Mem),
    .Enable_Write_B_Mem(Enable_Write_B_Mem),
    .Data_Output_B_Mem1(Data_Output_B_Mem1),
    .dbg_state(dbg_state)
  );

  // ---------------- behavioural dual-port RAM ----------------
  logic [DW-1:0] mem [N];
  logic [DW-1:0] mem_q = '0;
  always @(posedge clk) begin
    if (Enable_Write_A_Mem) mem[Address_A] <= Data_Input_A_Mem1;
    if (Enable_Read_B_Mem)  mem_q <= mem[Address_B];
  end
  assign Data_Output_B_Mem1 = mem_q;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];
  int  wr_cnt, rd_cnt, acc_cnt, done_cnt;
  bit  ovf_seen = 1'b0;
  bit  clash_seen = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    wr_cnt = 0; rd_cnt = 0; acc_cnt = 0; done_cnt = 0;
  endtask

  task automatic fill_exp(input int base);
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(DW'(base + i));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [DW-1:0] w;
    if (!reset) begin
      if ((rd_cnt - acc_cnt) > 2) ovf_seen = 1'b1;
      if (Enable_Write_A_Mem && Enable_Read_B_Mem && (Address_A == Address_B)) clash_seen = 1'b1;
      if (Enable_Write_A_Mem) wr_cnt++;
      if (Enable_Read_B_Mem)  rd_cnt++;
      if (done)               done_cnt++;
      if (out_valid && out_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL out_word actual=%0d required=none", out_data);
        end else begin
          w = exp_q.pop_front();
          chk("out_word", out_data, w);
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_done"},      done, 0);
    chk({tag, "_in_ready"},  in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_we_a"},      Enable_Write_A_Mem, 0);
    chk({tag, "_re_b"},      Enable_Read_B_Mem, 0);
    chk({tag, "_re_a"},      Enable_Read_A_Mem, 0);
    chk({tag, "_we_b"},      Enable_Write_B_Mem, 0);
    chk({tag, "_addr_a"},    DW'(Address_A), 0);
    chk({tag, "_addr_b"},    DW'(Address_B), 0);
    chk({tag, "_out_data"},  out_data, 0);
  endtask

  // One full map with optional input gaps, random out_ready and start spam.
  task automatic run_map(input string tag, input int base, input bit gaps,
                         input bit rnd_ready, input bit spam, input int budget);
    int idx;
    int cyc;
    fill_exp(base);
    clear_counts();
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    start = 1'b0;
    idx = 0;
    cyc = 0;
    while (done_cnt == 0 && cyc < budget) begin
      in_valid  = (idx < N) && (!gaps || ($urandom_range(0, 3) != 0));
      in_data   = DW'(base + idx);
      out_ready = !rnd_ready || ($urandom_range(0, 1) == 1);
      start     = spam && busy && ($urandom_range(0, 2) == 0);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      tick();
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    chk({tag, "_done_in_budget"}, DW'(done_cnt > 0), 1);
    repeat (3) tick();
    @(negedge clk);
    chk({tag, "_done_count"}, DW'(done_cnt), 1);
    chk({tag, "_idle_after"}, busy, 0);
    chk({tag, "_writes"},     DW'(wr_cnt), N);
    chk({tag, "_reads"},      DW'(rd_cnt), N);
    chk({tag, "_accepted"},   DW'(acc_cnt), N);
    chk({tag, "_exp_empty"},  DW'(exp_q.size()), 0);
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          busy;
    logic          in_ready;
    logic          we;
    logic [AW-1:0] addr_a;
    logic          re;
    logic [AW-1:0] addr_b;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          done;
  } vec_t;

  vec_t vecs[NV];

  initial begin
    int nv;
    // Cycle-accurate timeline of one map with in_valid and out_ready held
    // high: start at cycle 0, writes on cycles 1..16, reads from FIRST_RE,
    // words out from FIRST_OV, done the cycle after the last word.
    for (int k = 0; k < NV; k++) begin
      vecs[k].start     = (k == 0);
      vecs[k].in_valid  = (k >= 1 && k <= N);
      vecs[k].in_data   = (k >= 1) ? DW'(k - 1) : '0;
      vecs[k].out_ready = 1'b1;
      vecs[k].busy      = (k >= 1 && k <= LAST);
      vecs[k].in_ready  = (k >= 1 && k <= N);
      vecs[k].we        = (k >= 1 && k <= N);
      vecs[k].addr_a    = (k >= 1 && k <= N) ? AW'(k - 1) : '0;
      vecs[k].re        = (k >= FIRST_RE && k < FIRST_RE + N);
      vecs[k].addr_b    = AW'(k - FIRST_RE);
      vecs[k].out_valid = (k >= FIRST_OV && k <= LAST);
      vecs[k].out_data  = DW'(k - FIRST_OV);
      vecs[k].done      = (k == LAST + 1);
    end

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    clear_counts();
    repeat (2) tick();
    check_reset_vals("rst0");
    tick();
    reset = 1'b0;

    // ---- 1 / 6: table-driven single map ----
    fill_exp(0);
    clear_counts();
    for (int k = 0; k < NV; k++) begin
      start     = vecs[k].start;
      in_valid  = vecs[k].in_valid;
      in_data   = vecs[k].in_data;
      out_ready = vecs[k].out_ready;
      @(negedge clk);
      chk($sformatf("v%0d_busy", k),      busy,               vecs[k].busy);
      chk($sformatf("v%0d_in_ready", k),  in_ready,           vecs[k].in_ready);
      chk($sformatf("v%0d_we_a", k),      Enable_Write_A_Mem, vecs[k].we);
      chk($sformatf("v%0d_addr_a", k),    DW'(Address_A),     DW'(vecs[k].addr_a));
      chk($sformatf("v%0d_re_b", k),      Enable_Read_B_Mem,  vecs[k].re);
      if (vecs[k].re)
        chk($sformatf("v%0d_addr_b", k),  DW'(Address_B),     DW'(vecs[k].addr_b));
      chk($sformatf("v%0d_out_valid", k), out_valid,          vecs[k].out_valid);
      if (vecs[k].out_valid)
        chk($sformatf("v%0d_out_data", k), out_data,          vecs[k].out_data);
      chk($sformatf("v%0d_done", k),      done,               vecs[k].done);
      tick();
    end
    start = 1'b0; in_valid = 1'b0;
    chk("t1_done_count", DW'(done_cnt), 1);
    chk("t1_exp_empty",  DW'(exp_q.size()), 0);

    // ---- 3: out_ready low through drain ----
    fill_exp(300);
    clear_counts();
    start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(300 + i);
      tick();
    end
    in_valid = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    chk("t3_reads_stalled", DW'(rd_cnt), 2);
    chk("t3_valid_held",    out_valid, 1);
    chk("t3_data_held",     out_data, 300);
    chk("t3_busy",          busy, 1);
    tick();
    out_ready = 1'b1;
    nv = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (out_valid) nv++;
      tick();
    end
    chk("t3_back_to_back", DW'(nv), N);
    @(negedge clk);
    chk("t3_done",      done, 1);
    chk("t3_accepted",  DW'(acc_cnt), N);
    chk("t3_exp_empty", DW'(exp_q.size()), 0);
    tick();

    // ---- 2: random gaps and random out_ready ----
    run_map("t2a", 200, 1'b1, 1'b1, 1'b0, 400);
    run_map("t2b", 700, 1'b1, 1'b1, 1'b0, 400);

    // ---- 5: start pulsed during LOAD and DRAIN ----
    run_map("t5a", 500, 1'b0, 1'b0, 1'b1, 200);
    run_map("t5b", 600, 1'b1, 1'b1, 1'b1, 400);

    // ---- 4: reset at write 7, then a fresh map ----
    fill_exp(80);
    clear_counts();
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(80 + i);
      tick();
    end
    in_valid = 1'b1;
    in_data  = DW'(87);
    reset    = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check_reset_vals("t4_rst");
    tick();
    reset = 1'b0;
    run_map("t4", 100, 1'b0, 1'b0, 1'b0, 200);

    chk("outstanding_le_2", DW'(ovf_seen), 0);
    chk("no_same_addr_rw",  DW'(clash_seen), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
